renkon_conv_tree: RTL and testbench

Pipelined 5x5 multiply-accumulate stage that consumes the 25-pixel window from the line buffer each cycle and produces one fixed-point convolution result per valid window. It holds a 25-entry weight register file loaded by the controller, masks taps for 3x3 filters, and saturates the result to DWIDTH. It sits directly downstream of the line buffer and feeds the channel accumulator and activation stages.

---
 rtl/renkon_conv_tree.sv | 121 ++++++++++++
 tb/tb_renkon_conv_tree.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/renkon_conv_tree.sv
// renkon_conv_tree: pipelined 5x5 fixed-point MAC with 3x3 tap masking and output saturation.
// Define RENKON_CONV_ROUND_EN to round half up before the final shift (default: truncate).

module renkon_conv_tap #(
  parameter int DWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic signed [DWIDTH-1:0] pix_i,
  input  logic signed [DWIDTH-1:0] wt_i,
  input  logic                     en_i,
  output logic [2*DWIDTH-1:0]      prod_o
);
  logic signed [2*DWIDTH-1:0] prod_d, prod_q;

  always_comb begin
    prod_d = '0;
    if (en_i) prod_d = (2*DWIDTH)'(pix_i) * (2*DWIDTH)'(wt_i);
  end

  always_ff @(posedge clk or negedge xrst)
    if (!xrst) prod_q <= '0;
    else       prod_q <= prod_d;

  assign prod_o = prod_q;
endmodule

module renkon_conv_tree #(
  parameter int DWIDTH    = 16,
  parameter int FRACWIDTH = 8,
  parameter int LWIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      wt_we_i,
  input  logic [4:0]                wt_addr_i,
  input  logic signed [DWIDTH-1:0]  wt_data_i,
  input  logic [LWIDTH-1:0]         fil_size_i,
  input  logic                      pix_valid_i,
  input  logic [24:0][DWIDTH-1:0]   pixel_i,
  output logic                      out_valid_o,
  output logic signed [DWIDTH-1:0]  fmap_o
);
  localparam int NTAP   = 25;
  localparam int PW     = 2*DWIDTH;
  localparam int RW     = PW+3;
  localparam int TW     = PW+5;
  localparam int STAGES = 4;
  localparam logic signed [TW-1:0] SMAX = {{(TW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] SMIN = {{(TW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  logic [NTAP-1:0][DWIDTH-1:0] wt_q;
  logic [NTAP-1:0][PW-1:0]     prod;
  logic [4:0][RW-1:0]          row_d, row_q;
  logic signed [TW-1:0]        tot_d, tot_q, rnd, shf;
  logic signed [DWIDTH-1:0]    fmap_d, fmap_q;
  logic [STAGES:1]             vld_pipe_q;
  logic                        fil3;

  always_ff @(posedge clk or negedge xrst)
    if (!xrst) wt_q <= '0;
    else if (wt_we_i && wt_addr_i < 5'd25) wt_q[wt_addr_i] <= wt_data_i;

  assign fil3 = (fil_size_i == LWIDTH'(3));

  // S1: one registered multiplier per tap; taps outside the 3x3 corner drop out for 3x3 filters
  for (genvar r = 0; r < 5; r++) begin : g_row
    for (genvar c = 0; c < 5; c++) begin : g_col
      localparam bit IN3 = (r < 3) && (c < 3);
      renkon_conv_tap #(.DWIDTH(DWIDTH)) u_tap (
        .clk    (clk),
        .xrst   (xrst),
        .pix_i  ($signed(pixel_i[r*5+c])),
        .wt_i   ($signed(wt_q[r*5+c])),
        .en_i   (IN3 || !fil3),
        .prod_o (prod[r*5+c])
      );
    end
  end

  always_comb begin
    row_d = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        row_d[r] = row_d[r] + RW'($signed(prod[r*5+c]));
  end

  always_comb begin
    tot_d = '0;
    for (int r = 0; r < 5; r++) tot_d = tot_d + TW'($signed(row_q[r]));
  end

  always_comb begin
`ifdef RENKON_CONV_ROUND_EN
    rnd = tot_q + (TW'(1) <<< (FRACWIDTH-1));
`else
    rnd = tot_q;
`endif
    shf = rnd >>> FRACWIDTH;
    if (shf > SMAX)      fmap_d = SMAX[DWIDTH-1:0];
    else if (shf < SMIN) fmap_d = SMIN[DWIDTH-1:0];
    else                 fmap_d = shf[DWIDTH-1:0];
  end

  // fmap only moves on valid results so it holds through bubbles
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      row_q      <= '0;
      tot_q      <= '0;
      fmap_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      row_q      <= row_d;
      tot_q      <= tot_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], pix_valid_i};
      if (vld_pipe_q[STAGES-1]) fmap_q <= fmap_d;
    end

  assign out_valid_o = vld_pipe_q[STAGES];
  assign fmap_o      = fmap_q;
endmodule

// File: tb/tb_renkon_conv_tree.sv
// Directed bench for renkon_conv_tree: latency, masking, saturation, rounding, streaming, reset.
module tb_renkon_conv_tree;
  localparam int DW = 16;
  localparam int LW = 3;

  logic                 clk = 1'b0;
  logic                 xrst;
  logic                 wt_we;
  logic [4:0]           wt_addr;
  logic signed [DW-1:0] wt_data;
  logic [LW-1:0]        fil_size;
  logic                 pix_valid;
  logic [24:0][DW-1:0]  pix;
  logic                 out_valid;
  logic signed [DW-1:0] fmap;

  int checks = 0;
  int errors = 0;

  renkon_conv_tree #(.DWIDTH(DW), .FRACWIDTH(8), .LWIDTH(LW)) dut (
    .clk         (clk),
    .xrst        (xrst),
    .wt_we_i     (wt_we),
    .wt_addr_i   (wt_addr),
    .wt_data_i   (wt_data),
    .fil_size_i  (fil_size),
    .pix_valid_i (pix_valid),
    .pixel_i     (pix),
    .out_valid_o (out_valid),
    .fmap_o      (fmap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input int addr, input logic signed [DW-1:0] data);
    wt_we = 1'b1; wt_addr = 5'(addr); wt_data = data;
    @(negedge clk);
    wt_we = 1'b0;
  endtask

  task automatic set_all_w(input logic signed [DW-1:0] v);
    for (int i = 0; i < 25; i++) wr_w(i, v);
  endtask

  task automatic set_pix(input logic signed [DW-1:0] v);
    for (int i = 0; i < 25; i++) pix[i] = v;
  endtask

  // single window, then latency, result and hold checks
  task automatic pulse_chk(input string tag, input logic signed [31:0] exp);
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_early_ov"}, {31'd0, out_valid}, 0);
      @(negedge clk);
    end
    chk({tag, "_ov"}, {31'd0, out_valid}, 1);
    chk({tag, "_fmap"}, fmap, exp);
    @(negedge clk);
    chk({tag, "_ov_off"}, {31'd0, out_valid}, 0);
    chk({tag, "_hold"}, fmap, exp);
  endtask

  initial begin
    xrst = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    fil_size = 3'd5; pix_valid = 1'b0; pix = '0;
    #12;
    chk("rst_ov", {31'd0, out_valid}, 0);
    chk("rst_fmap", fmap, 0);
    @(negedge clk);
    xrst = 1'b1;
    @(negedge clk);

    set_all_w(16'sd256);
    set_pix(16'sd256);
    pulse_chk("full5", 6400);

    fil_size = 3'd3;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r >= 3 || c >= 3) pix[r*5+c] = 16'sd1000;
    pulse_chk("mask3", 2304);
    fil_size = 3'd5;

    set_all_w(16'sd32767);
    set_pix(16'sd32767);
    pulse_chk("sat_pos", 32767);
    set_pix(-16'sd32768);
    pulse_chk("sat_neg", -32768);

    set_all_w(16'sd0);
    wr_w(0, 16'sd1);
    set_pix(16'sd0);
    pix[0] = 16'sd128;
`ifdef RENKON_CONV_ROUND_EN
    pulse_chk("half", 1);
    pix[0] = -16'sd1;
    pulse_chk("neg1", 0);
`else
    pulse_chk("half", 0);
    pix[0] = -16'sd1;
    pulse_chk("neg1", -1);
`endif

    // stream: w0=256, w12 256 -> 512 in window 5; window k: p00=16k, p22=10+k
    set_all_w(16'sd0);
    wr_w(0, 16'sd256);
    wr_w(12, 16'sd256);
    set_pix(16'sd0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    for (int t = 0; t <= 14; t++) begin
      if (t >= 4 && t <= 13) begin
        chk("strm_ov", {31'd0, out_valid}, 1);
        chk("strm_fmap", fmap, (t-4 <= 5) ? 17*(t-4)+10 : 18*(t-4)+20);
      end else begin
        chk("strm_ov_idle", {31'd0, out_valid}, 0);
      end
      if (t < 10) begin
        pix[0] = 16'(16*t); pix[12] = 16'(10+t); pix_valid = 1'b1;
        wt_we   = (t == 2) || (t == 5);
        wt_addr = (t == 2) ? 5'd27 : 5'd12;
        wt_data = (t == 2) ? 16'sh7fff : 16'sd512;
      end else begin
        pix_valid = 1'b0; wt_we = 1'b0;
      end
      @(negedge clk);
    end

    // reset with three windows still in flight
    set_all_w(16'sd256);
    set_pix(16'sd256);
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    chk("pre_rst_ov", {31'd0, out_valid}, 1);
    chk("pre_rst_fmap", fmap, 6400);
    xrst = 1'b0;
    #1;
    chk("mid_rst_ov", {31'd0, out_valid}, 0);
    chk("mid_rst_fmap", fmap, 0);
    @(negedge clk);
    xrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_ov", {31'd0, out_valid}, 0);
      @(negedge clk);
    end
    set_pix(-16'sd1);
    pulse_chk("rst_wt", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
